seg_decode: RTL and testbench

Reverse-direction companion to the BCD 7-segment decoder: samples a multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode selects) and recovers the 4-bit display code of every digit. It requires a pattern to be stable for a programmable number of samples before accepting it, then flags unrecognised glyphs. It raises a single-cycle frame pulse once every digit has been captured. It sits on the board-test/loopback path, monitoring the display outputs for self-check and for automated verification of the display subsystem.

---
 rtl/seg_decode.sv | 173 +++++++++++++++++
 tb/tb_seg_decode.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seg_decode.sv
// seg_decode: recovers per-digit 4-bit codes from a multiplexed active-low 7-segment bus.
// Optional feature macro SEG_DECODE_ERR_CNT_EN adds a saturating 8-bit unrecognised-glyph counter (err_cnt).
module seg_decode #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CNT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_en,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     an_n,
    output logic [4*DIGITS-1:0]   codes,
    output logic [DIGITS-1:0]     err,
    output logic                  frame_valid,
    output logic [1:0]            dbg_state
`ifdef SEG_DECODE_ERR_CNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(STABLE_CNT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       prev_idx_q, prev_idx_d;
    logic [6:0]          prev_seg_q, prev_seg_d;
    logic [DIGITS-1:0]   mask_q, mask_d;
    logic [4*DIGITS-1:0] codes_q, codes_d;
    logic [DIGITS-1:0]   err_q, err_d;
    logic                frame_q, frame_d;

    logic [DIGITS-1:0]   sel;
    logic                qual;
    logic [IW-1:0]       idx_new;
    logic [4:0]          dec;
    logic                same;
    logic                capture;
    logic [CW-1:0]       cnt_inc;
    logic [DIGITS-1:0]   mask_set;

    // Returns {unrecognised, code}; unknown patterns decode to code 0.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b1000000: decode = 5'h00;
            7'b1111001: decode = 5'h01;
            7'b0100100: decode = 5'h02;
            7'b0110000: decode = 5'h03;
            7'b0011001: decode = 5'h04;
            7'b0010010: decode = 5'h05;
            7'b0000010: decode = 5'h06;
            7'b1011000: decode = 5'h07;
            7'b0000000: decode = 5'h08;
            7'b0010000: decode = 5'h09;
            7'b1111111: decode = 5'h0A;
            7'b0111111: decode = 5'h0B;
            7'b0001001: decode = 5'h0C;
            7'b1000111: decode = 5'h0D;
            7'b0000110: decode = 5'h0E;
            7'b0001100: decode = 5'h0F;
            default:    decode = 5'h10;
        endcase
    endfunction

    // sample_en is a strobe, not a handshake: inputs are consumed only on edges where it is
    // high, there is no backpressure, and with it low every register except frame_valid holds.
    always_comb begin
        sel     = ~an_n;
        qual    = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
        idx_new = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel[i]) idx_new = IW'(i);
        end
        dec     = decode(seg_n);
        same    = (state_q != IDLE) && (idx_new == prev_idx_q) && (seg_n == prev_seg_q);
        cnt_inc = (cnt_q == CW'(STABLE_CNT)) ? cnt_q : cnt_q + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prev_idx_d = prev_idx_q;
        prev_seg_d = prev_seg_q;
        mask_d     = mask_q;
        codes_d    = codes_q;
        err_d      = err_q;
        frame_d    = 1'b0;
        capture    = 1'b0;
        mask_set   = mask_q | (DIGITS'(1) << idx_new);

        if (sample_en) begin
            if (!qual) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (!(same && state_q == LOCKED)) begin
                if (same) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(STABLE_CNT)) begin
                        capture = 1'b1;
                        state_d = LOCKED;
                    end
                end else begin
                    // New digit or glyph: restart tracking from this sample.
                    prev_idx_d = idx_new;
                    prev_seg_d = seg_n;
                    cnt_d      = CW'(1);
                    if (STABLE_CNT == 1) begin
                        capture = 1'b1;
                        state_d = LOCKED;
                    end else begin
                        state_d = TRACK;
                    end
                end
            end
        end

        if (capture) begin
            codes_d[{idx_new, 2'b00} +: 4] = dec[3:0];
            err_d[idx_new]                 = dec[4];
            if (mask_set == {DIGITS{1'b1}}) begin
                frame_d = 1'b1;
                mask_d  = '0;
            end else begin
                mask_d  = mask_set;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            prev_idx_q <= '0;
            prev_seg_q <= '0;
            mask_q     <= '0;
            codes_q    <= {DIGITS{4'hA}};
            err_q      <= '0;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prev_idx_q <= prev_idx_d;
            prev_seg_q <= prev_seg_d;
            mask_q     <= mask_d;
            codes_q    <= codes_d;
            err_q      <= err_d;
            frame_q    <= frame_d;
        end
    end

`ifdef SEG_DECODE_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (capture && dec[4] && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign codes       = codes_q;
    assign err         = err_q;
    assign frame_valid = frame_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_seg_decode.sv
// Directed bench for seg_decode (DIGITS=4, STABLE_CNT=4) with hand-computed expected values.
module tb_seg_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_en;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic [15:0] codes;
    logic [3:0]  err;
    logic        frame_valid;
    logic [1:0]  dbg_state;
`ifdef SEG_DECODE_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    int n_vec    = 0;
    int n_miscmp = 0;
    int frames   = 0;

    seg_decode #(.DIGITS(4), .STABLE_CNT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_en   (sample_en),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .codes       (codes),
        .err         (err),
        .frame_valid (frame_valid),
        .dbg_state   (dbg_state)
`ifdef SEG_DECODE_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) frames++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One strobe = one rising edge with sample_en high; outputs are read 1 time unit later.
    task automatic strobe(input logic [3:0] an, input logic [6:0] seg, input int n);
        repeat (n) begin
            @(negedge clk);
            an_n      = an;
            seg_n     = seg;
            sample_en = 1'b1;
            @(posedge clk);
            #1;
            sample_en = 1'b0;
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        sample_en = 1'b0;
        an_n      = 4'hF;
        seg_n     = 7'h7F;
        repeat (2) @(posedge clk);
        #1;
        check("rst_codes", codes, 16'hAAAA);
        check("rst_err", err, 4'h0);
        check("rst_frame", frame_valid, 1'b0);
        check("rst_state", dbg_state, 2'd0);
`ifdef SEG_DECODE_ERR_CNT_EN
        check("rst_err_cnt", err_cnt, 8'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // stability threshold
        strobe(4'b1110, 7'b0100100, 3);
        strobe(4'b1110, 7'b0110000, 1);
        check("stab_nocap", codes, 16'hAAAA);
        check("stab_track", dbg_state, 2'd1);
        strobe(4'b1110, 7'b0110000, 2);
        check("stab_cnt3", codes, 16'hAAAA);
        strobe(4'b1110, 7'b0110000, 2);
        check("stab_cap", codes, 16'hAAA3);
        check("stab_err", err, 4'h0);
        check("stab_locked", dbg_state, 2'd2);

        // full frame
        strobe(4'b1110, 7'b1111001, 4);
        strobe(4'b1101, 7'b0000110, 4);
        strobe(4'b1011, 7'b0001001, 4);
        check("frame_early", frame_valid, 1'b0);
        strobe(4'b0111, 7'b1000111, 4);
        check("frame_codes", codes, 16'hDCE1);
        check("frame_pulse", frame_valid, 1'b1);
        idle_cycle();
        check("frame_drop", frame_valid, 1'b0);
        check("frame_count1", frames, 1);

        // error glyph
        strobe(4'b1011, 7'b1110011, 4);
        check("errg_codes", codes, 16'hD0E1);
        check("errg_err", err, 4'b0100);
`ifdef SEG_DECODE_ERR_CNT_EN
        check("errg_err_cnt", err_cnt, 8'd1);
`endif

        // invalid select mid-count
        strobe(4'b1101, 7'b0010010, 2);
        strobe(4'b1100, 7'b0010010, 1);
        check("inv_idle", dbg_state, 2'd0);
        strobe(4'b1101, 7'b0010010, 3);
        check("inv_nocap", codes, 16'hD0E1);
        strobe(4'b1101, 7'b0010010, 1);
        check("inv_cap", codes, 16'hD051);
        check("inv_err", err, 4'b0100);

        // locked hold
        strobe(4'b0111, 7'b0000000, 4);
        check("hold_cap", codes, 16'h8051);
        strobe(4'b0111, 7'b0000000, 16);
        check("hold_codes", codes, 16'h8051);
        check("hold_state", dbg_state, 2'd2);
        check("hold_noframe", frames, 1);
        strobe(4'b1110, 7'b0100100, 4);
        check("hold_fill_codes", codes, 16'h8052);
        check("hold_fill_pulse", frame_valid, 1'b1);
        idle_cycle();
        check("frame_count2", frames, 2);

        // sample_en low: nothing moves
        an_n  = 4'b1101;
        seg_n = 7'b1011000;
        repeat (6) idle_cycle();
        check("sen_codes", codes, 16'h8052);
        check("sen_state", dbg_state, 2'd2);

        // reset mid-tracking
        strobe(4'b1110, 7'b0011001, 3);
        check("mid_track", dbg_state, 2'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_codes", codes, 16'hAAAA);
        check("arst_err", err, 4'h0);
        check("arst_state", dbg_state, 2'd0);
        check("arst_frame", frame_valid, 1'b0);
`ifdef SEG_DECODE_ERR_CNT_EN
        check("arst_err_cnt", err_cnt, 8'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        strobe(4'b1110, 7'b0011001, 3);
        check("post_rst_nocap", codes, 16'hAAAA);
        strobe(4'b1110, 7'b0011001, 1);
        check("post_rst_cap", codes, 16'hAAA4);
        strobe(4'b1101, 7'b0111111, 4);
        check("dash_cap", codes, 16'hAAB4);
        check("dash_err", err, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
